// File: rtl/line_col_buffer3_pkg.sv
// Shared constants for the 3x1 column buffer and the Sobel stage that consumes its columns.
package line_col_buffer3_pkg;

    // Number of rows in one emitted column.
    localparam int windowSize = 3;

    // Slice order inside a packed column: top row lives in the lowest slice.
    localparam int ROW_TOP = 0;
    localparam int ROW_MID = 1;
    localparam int ROW_CUR = 2;

    // Address width needed to index a RAM of the given depth (at least one bit).
    function automatic int ram_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_col_buffer3_line_ram.sv
// Simple dual-port line RAM with asynchronous read; a write lands at the clock edge,
// so a read of the same address in the write cycle returns the old word.
module line_ram #(
    parameter int depth = 640,
    parameter int width = 16,
    parameter int addrW = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [addrW-1:0] waddr,
    input  logic [width-1:0] wdata,
    input  logic [addrW-1:0] raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    assign rdata = mem[raddr];

    // Store one word per enabled cycle; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/line_col_buffer3.sv
// Raster-stream line buffer: keeps the two previous lines and emits, one cycle after each
// accepted pixel, the vertical 3x1 column {row y, row y-1, row y-2} at the same x.
module line_col_buffer3
    import line_col_buffer3_pkg::*;
#(
    parameter int dataW = 8,
    parameter int imgW  = 640,
    parameter int imgH  = 480,
    parameter int xW    = 12,
    parameter int yW    = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        sof,
    input  logic [dataW-1:0]            pix_in,
    output logic [dataW*windowSize-1:0] PixCol3x1,
    output logic                        col_valid,
    output logic [xW-1:0]               col_x,
    output logic [yW-1:0]               col_y,
    output logic                        eol,
    output logic                        eof
);

    localparam int ramAw = ram_addr_width(imgW);
    localparam logic [xW-1:0] xLast = xW'(imgW - 1);
    localparam logic [yW-1:0] yLast = yW'(imgH - 1);
    localparam logic [yW-1:0] firstValidRow = yW'(windowSize - 1);

    logic [xW-1:0]              x_q;
    logic [yW-1:0]              y_q;
    logic [xW-1:0]              x_e;
    logic [yW-1:0]              y_e;
    logic [xW-1:0]              x_next;
    logic [yW-1:0]              y_next;
    logic                       at_eol;
    logic                       at_eof;
    logic [2*dataW-1:0]         ram_rd;
    logic [2*dataW-1:0]         ram_wr;
    logic [dataW-1:0]           line_a;
    logic [dataW-1:0]           line_b;
    logic [dataW*windowSize-1:0] col_next;

    // Effective position (sof forces the pixel to (0,0)) and the raster-order successor.
    always_comb begin
        x_e    = sof ? '0 : x_q;
        y_e    = sof ? '0 : y_q;
        at_eol = (x_e == xLast);
        at_eof = at_eol && (y_e == yLast);
        x_next = at_eol ? '0 : x_e + xW'(1);
        y_next = y_e;
        if (at_eol) begin
            y_next = (y_e == yLast) ? '0 : y_e + yW'(1);
        end
    end

    // Both lines share one RAM word: low half is row y-2, high half is row y-1.
    assign line_a = ram_rd[dataW-1:0];
    assign line_b = ram_rd[2*dataW-1:dataW];
    assign ram_wr = {pix_in, line_b};

    line_ram #(
        .depth (imgW),
        .width (2 * dataW),
        .addrW (ramAw)
    ) u_line_ram (
        .clk   (clk),
        .we    (en),
        .waddr (x_e[ramAw-1:0]),
        .wdata (ram_wr),
        .raddr (x_e[ramAw-1:0]),
        .rdata (ram_rd)
    );

    // Assemble the column with the top row in the lowest slice.
    always_comb begin
        col_next = '0;
        col_next[ROW_TOP*dataW +: dataW] = line_a;
        col_next[ROW_MID*dataW +: dataW] = line_b;
        col_next[ROW_CUR*dataW +: dataW] = pix_in;
    end

    // Raster position counters advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            x_q <= x_next;
            y_q <= y_next;
        end
    end

    // Registered column outputs; strobes pulse for one cycle, data holds while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_valid <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            PixCol3x1 <= '0;
            col_x     <= '0;
            col_y     <= '0;
        end else begin
            col_valid <= en && (y_e >= firstValidRow);
            eol       <= en && at_eol;
            eof       <= en && at_eof;
            if (en) begin
                PixCol3x1 <= col_next;
                col_x     <= x_e;
                col_y     <= y_e;
            end
        end
    end

endmodule

// File: tb/tb_line_col_buffer3.sv
// Scoreboard bench: stimulus updates an image-array reference model and queues the expected
// columns; an independent monitor pops and compares whenever the DUT strobes col_valid.
module tb_line_col_buffer3;

    localparam int dataW = 8;
    localparam int imgW  = 6;
    localparam int imgH  = 5;
    localparam int xW    = 12;
    localparam int yW    = 12;
    localparam int frameSize = imgW * imgH;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               sof;
    logic [dataW-1:0]   pix_in;
    logic [dataW*3-1:0] PixCol3x1;
    logic               col_valid;
    logic [xW-1:0]      col_x;
    logic [yW-1:0]      col_y;
    logic               eol;
    logic               eof;

    typedef struct {
        logic [dataW*3-1:0] col;
        int                 x;
        int                 y;
        logic               eol;
        logic               eof;
    } exp_t;

    exp_t             sb[$];
    logic [dataW-1:0] img [imgH][imgW];
    int               mx = 0;
    int               my = 0;
    int               checks = 0;
    int               failures = 0;
    int               pushed = 0;
    int               seen = 0;

    always #5 clk = ~clk;

    line_col_buffer3 #(
        .dataW (dataW),
        .imgW  (imgW),
        .imgH  (imgH),
        .xW    (xW),
        .yW    (yW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sof       (sof),
        .pix_in    (pix_in),
        .PixCol3x1 (PixCol3x1),
        .col_valid (col_valid),
        .col_x     (col_x),
        .col_y     (col_y),
        .eol       (eol),
        .eof       (eof)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus; the model places the pixel in a full image array and, from
    // row 2 on, queues the column read straight out of that image.
    task automatic applyStimulus(input logic e, input logic s, input logic [dataW-1:0] p);
        exp_t t;
        int   xe;
        int   ye;
        @(negedge clk);
        en     = e;
        sof    = s;
        pix_in = p;
        if (e) begin
            xe = s ? 0 : mx;
            ye = s ? 0 : my;
            img[ye][xe] = p;
            if (ye >= 2) begin
                t.col = {img[ye][xe], img[ye-1][xe], img[ye-2][xe]};
                t.x   = xe;
                t.y   = ye;
                t.eol = (xe == imgW - 1);
                t.eof = (xe == imgW - 1) && (ye == imgH - 1);
                sb.push_back(t);
                pushed++;
            end
            if (xe == imgW - 1) begin
                mx = 0;
                my = (ye == imgH - 1) ? 0 : ye + 1;
            end else begin
                mx = xe + 1;
                my = ye;
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        @(negedge clk);
        checkOutput({tag, "_col_valid"}, 64'(col_valid), 64'd0);
        checkOutput({tag, "_eol"},       64'(eol),       64'd0);
        checkOutput({tag, "_eof"},       64'(eof),       64'd0);
        checkOutput({tag, "_PixCol3x1"}, 64'(PixCol3x1), 64'd0);
        checkOutput({tag, "_col_x"},     64'(col_x),     64'd0);
        checkOutput({tag, "_col_y"},     64'(col_y),     64'd0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n  = 1'b0;
        en     = 1'b0;
        sof    = 1'b0;
        checkResetState("midreset");
        rst_n = 1'b1;
        mx = 0;
        my = 0;
    endtask

    // Monitor: every strobed column must match the oldest outstanding expectation.
    initial begin
        exp_t t;
        forever begin
            @(posedge clk);
            #1;
            if (col_valid === 1'b1) begin
                seen++;
                checkOutput("column_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    t = sb.pop_front();
                    checkOutput("PixCol3x1", 64'(PixCol3x1), 64'(t.col));
                    checkOutput("col_x",     64'(col_x),     64'(t.x));
                    checkOutput("col_y",     64'(col_y),     64'(t.y));
                    checkOutput("eol",       64'(eol),       64'(t.eol));
                    checkOutput("eof",       64'(eof),       64'(t.eof));
                end
            end
        end
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        sof    = 1'b0;
        pix_in = '0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        // Full-rate frame of sequential pixels with sof on the first one.
        for (int i = 0; i < frameSize; i++) applyStimulus(1'b1, i == 0, dataW'(i));
        applyStimulus(1'b0, 1'b0, '0);

        // Same shape with en alternating; sof during idle cycles must be ignored.
        for (int i = 0; i < frameSize; i++) begin
            applyStimulus(1'b1, i == 0, dataW'(100 + i));
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), dataW'($urandom));
        end

        // sof reasserted part-way through a frame, then a full new frame and more.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i == 0, dataW'($urandom));
        for (int i = 0; i < frameSize + 8; i++) applyStimulus(1'b1, i == 0, dataW'($urandom));

        // Frames wrapping without sof, random enable density.
        for (int i = 0; i < 3 * frameSize; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 1'b0, dataW'($urandom));
        end

        // Reset part-way through a row, then the sequential frame again.
        for (int i = 0; i < imgW + 3; i++) applyStimulus(1'b1, 1'b0, dataW'($urandom));
        pulseReset();
        for (int i = 0; i < frameSize; i++) applyStimulus(1'b1, i == 0, dataW'(i));

        // Random data over three frames, full rate then sparse.
        for (int i = 0; i < 3 * frameSize; i++) begin
            applyStimulus((i < frameSize) || ($urandom_range(0, 2) != 0), i == 0, dataW'($urandom));
        end

        repeat (3) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("queue_drained", 64'(sb.size()), 64'd0);
        checkOutput("valid_count",   64'(seen),      64'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
